// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and helpers for the PLL lock sequencer.
//   pll_seq_state_t : sequencer FSM states
//   cnt_w()         : bit width needed to hold 0..max_val (minimum 1)
//   LOCK_LOSS_CNT_W : width of the saturating lock-loss counter
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET_PLL,
    WAIT_LOCK,
    RUN,
    FAULT
  } pll_seq_state_t;

  localparam int LOCK_LOSS_CNT_W = 8;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with synchronous active-high reset.
//   clk : destination clock
//   rst : synchronous reset, clears both stages to 0
//   d   : asynchronous input
//   q   : synchronized output, lags d by two clk edges
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses the PLL reset, qualifies a synchronized lock as
// stable, then releases the downstream domain reset. Lock loss or lock timeout
// triggers bounded retries, after which the block parks in FAULT until relock.
//   refclk        : PLL reference clock, sole clock
//   rst           : synchronous active-high block reset
//   pll_locked    : PLL locked, asynchronous to refclk
//   relock_req    : single-cycle software relock request
//   pll_rst       : PLL reset output
//   domain_rst    : reset for logic on PLL output clocks
//   ready         : locked and qualified (== !domain_rst)
//   fault         : retries exhausted
//   retry_cnt     : attempts used in the current sequence
//   lock_loss_cnt : saturating count of lock losses while running
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                            refclk,
  input  logic                            rst,
  input  logic                            pll_locked,
  input  logic                            relock_req,
  output logic                            pll_rst,
  output logic                            domain_rst,
  output logic                            ready,
  output logic                            fault,
  output logic [cnt_w(MAX_RETRIES)-1:0]   retry_cnt,
  output logic [LOCK_LOSS_CNT_W-1:0]      lock_loss_cnt
);

  localparam int TMR_MAX = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int STB_W   = cnt_w(LOCK_STABLE_CYCLES);
  localparam int RTY_W   = cnt_w(MAX_RETRIES);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RST_PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_DONE = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [RTY_W-1:0] RTY_LAST = RTY_W'(MAX_RETRIES);

  pll_seq_state_t             state, state_n;
  logic [TMR_W-1:0]           timer, timer_n;
  logic [STB_W-1:0]           stable, stable_n;
  logic [RTY_W-1:0]           retry_n;
  logic [LOCK_LOSS_CNT_W-1:0] loss_n;
  logic                       pll_rst_n, domain_rst_n, fault_n;
  logic                       lock_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    stable_n = '0;
    retry_n  = retry_cnt;
    loss_n   = lock_loss_cnt;

    case (state)
      RESET_PLL: begin
        if (timer == RST_LAST) begin
          state_n = WAIT_LOCK;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end

      WAIT_LOCK: begin
        stable_n = lock_s ? stable + 1'b1 : '0;
        timer_n  = timer + 1'b1;
        // Completion is judged on the registered count, so the exit edge is
        // one past the Nth qualifying sample; it is tested first so that a
        // completion coinciding with timeout still wins.
        if (stable == STB_DONE) begin
          state_n  = RUN;
          retry_n  = '0;
          timer_n  = '0;
          stable_n = '0;
        end else if (timer == TMO_LAST) begin
          timer_n  = '0;
          stable_n = '0;
          if (retry_cnt == RTY_LAST) begin
            state_n = FAULT;
          end else begin
            state_n = RESET_PLL;
            retry_n = retry_cnt + 1'b1;
          end
        end
      end

      RUN: begin
        timer_n = '0;
        if (!lock_s || relock_req) begin
          state_n = RESET_PLL;
          retry_n = '0;
          if (!lock_s && (lock_loss_cnt != '1)) begin
            loss_n = lock_loss_cnt + 1'b1;
          end
        end
      end

      FAULT: begin
        timer_n = '0;
        if (relock_req) begin
          state_n = RESET_PLL;
          retry_n = '0;
        end
      end

      default: begin
        state_n = RESET_PLL;
        timer_n = '0;
      end
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register.
    pll_rst_n    = (state_n == RESET_PLL) || (state_n == FAULT);
    domain_rst_n = (state_n != RUN);
    fault_n      = (state_n == FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state         <= RESET_PLL;
      timer         <= '0;
      stable        <= '0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      domain_rst    <= 1'b1;
      ready         <= 1'b0;
      fault         <= 1'b0;
    end else begin
      state         <= state_n;
      timer         <= timer_n;
      stable        <= stable_n;
      retry_cnt     <= retry_n;
      lock_loss_cnt <= loss_n;
      pll_rst       <= pll_rst_n;
      domain_rst    <= domain_rst_n;
      ready         <= !domain_rst_n;
      fault         <= fault_n;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed self-checking bench for pll_lock_sequencer.
// Expected values are queued when stimulus is applied and popped when the
// corresponding DUT output is observed (sampled on the falling edge).
module tb_pll_lock_sequencer;

  localparam int RST = 4;
  localparam int STB = 8;
  localparam int TMO = 32;
  localparam int RTY = 2;

  localparam int S_PLL_RST    = 0;
  localparam int S_DOMAIN_RST = 1;
  localparam int S_READY      = 2;
  localparam int S_FAULT      = 3;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       domain_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RST),
    .LOCK_STABLE_CYCLES  (STB),
    .LOCK_TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES         (RTY)
  ) dut (
    .refclk        (refclk),
    .rst           (rst),
    .pll_locked    (pll_locked),
    .relock_req    (relock_req),
    .pll_rst       (pll_rst),
    .domain_rst    (domain_rst),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  // After the k-th rising edge, cyc reads k at the following falling edge.
  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  // Reset ordering: domain reset must cover any PLL reset, ready mirrors it.
  logic order_bad = 1'b0;
  always @(negedge refclk) begin
    if (cyc > 2) begin
      if ((pll_rst === 1'b1 && domain_rst === 1'b0) || (ready !== !domain_rst))
        order_bad = 1'b1;
    end
  end

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_assert++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int obs);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", obs, -999);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // Waits for a DUT output to reach val; at = cycle seen, or -1 on timeout.
  task automatic wait_sig(input int sel, input logic val, input int budget,
                          output int at);
    logic cur;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge refclk);
      case (sel)
        S_PLL_RST:    cur = pll_rst;
        S_DOMAIN_RST: cur = domain_rst;
        S_READY:      cur = ready;
        default:      cur = fault;
      endcase
      if (cur === val) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic check_reset_values(input string pfx);
    sb_push({pfx, "_pll_rst"}, 1);
    sb_push({pfx, "_domain_rst"}, 1);
    sb_push({pfx, "_ready"}, 0);
    sb_push({pfx, "_fault"}, 0);
    sb_push({pfx, "_retry_cnt"}, 0);
    sb_push({pfx, "_lock_loss_cnt"}, 0);
    sb_check(int'(pll_rst));
    sb_check(int'(domain_rst));
    sb_check(int'(ready));
    sb_check(int'(fault));
    sb_check(int'(retry_cnt));
    sb_check(int'(lock_loss_cnt));
  endtask

  initial begin
    int  c;
    int  t;
    int  f;
    logic loop_ok;

    rst        = 1'b1;
    pll_locked = 1'b0;
    relock_req = 1'b0;
    tick(4);
    check_reset_values("por");

    // Clean lock.
    rst = 1'b0;
    c   = cyc;
    sb_push("clean_pll_rst_fall", c + RST);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    tick(10);
    pll_locked = 1'b1;
    c = cyc;
    sb_push("clean_ready_rise", c + STB + 3);
    sb_push("clean_retry_cnt", 0);
    sb_push("clean_domain_rst", 0);
    wait_sig(S_READY, 1'b1, 40, t);
    sb_check(t);
    sb_check(int'(retry_cnt));
    sb_check(int'(domain_rst));

    // One-cycle lock loss in RUN, then automatic relock.
    tick(3);
    pll_locked = 1'b0;
    c = cyc;
    tick(1);
    pll_locked = 1'b1;
    sb_push("loss_domain_rst_at", c + 3);
    sb_push("loss_pll_rst_same_cycle", 1);
    sb_push("loss_cnt_1", 1);
    sb_push("loss_relock_ready", c + 3 + RST + STB + 1);
    wait_sig(S_DOMAIN_RST, 1'b1, 10, t);
    sb_check(t);
    sb_check(int'(pll_rst));
    sb_check(int'(lock_loss_cnt));
    wait_sig(S_READY, 1'b1, 40, t);
    sb_check(t);

    // Held lock loss, then glitchy lock in WAIT_LOCK.
    tick(2);
    pll_locked = 1'b0;
    c = cyc;
    sb_push("loss2_pll_rst_fall", c + 3 + RST);
    wait_sig(S_PLL_RST, 1'b1, 10, t);
    wait_sig(S_PLL_RST, 1'b0, 20, f);
    sb_check(f);
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    c = cyc;
    sb_push("glitch_ready_rise", c + STB + 3);
    sb_push("glitch_retry_cnt", 0);
    sb_push("glitch_loss_cnt", 2);
    wait_sig(S_READY, 1'b1, 40, t);
    sb_check(t);
    sb_check(int'(retry_cnt));
    sb_check(int'(lock_loss_cnt));

    // Lock loss and relock request reaching the FSM on the same edge.
    tick(3);
    pll_locked = 1'b0;
    c = cyc;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    sb_push("simul_domain_rst", 1);
    sb_push("simul_loss_cnt", 3);
    sb_push("simul_pll_rst_fall", c + 3 + RST);
    sb_push("simul_ready_rise", c + 3 + RST + STB + 1);
    sb_check(int'(domain_rst));
    sb_check(int'(lock_loss_cnt));
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    wait_sig(S_READY, 1'b1, 40, t);
    sb_check(t);

    // Relock request alone, request ignored in WAIT_LOCK, rst mid-WAIT_LOCK.
    tick(2);
    relock_req = 1'b1;
    c = cyc;
    tick(1);
    relock_req = 1'b0;
    sb_push("relock_domain_rst", 1);
    sb_push("relock_loss_cnt_kept", 3);
    sb_push("relock_pll_rst_fall", c + 1 + RST);
    sb_check(int'(domain_rst));
    sb_check(int'(lock_loss_cnt));
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    tick(1);
    relock_req = 1'b1;
    tick(1);
    relock_req = 1'b0;
    tick(1);
    sb_push("wait_relock_ignored_pll_rst", 0);
    sb_push("wait_relock_ignored_ready", 0);
    sb_check(int'(pll_rst));
    sb_check(int'(ready));
    rst = 1'b1;
    tick(1);
    check_reset_values("midwait_rst");

    // No lock: retries, then FAULT.
    pll_locked = 1'b0;
    tick(2);
    rst = 1'b0;
    c   = cyc;
    sb_push("nolock_fall1", c + RST);
    sb_push("nolock_rise2", c + RST + TMO);
    sb_push("nolock_retry1", 1);
    sb_push("nolock_fall2", c + 2 * RST + TMO);
    sb_push("nolock_rise3", c + 2 * (RST + TMO));
    sb_push("nolock_retry2", 2);
    sb_push("nolock_fault_rise", c + 3 * (RST + TMO));
    sb_push("nolock_fault_retry", 2);
    sb_push("nolock_fault_pll_rst", 1);
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    wait_sig(S_PLL_RST, 1'b1, 60, t);
    sb_check(t);
    sb_check(int'(retry_cnt));
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    wait_sig(S_PLL_RST, 1'b1, 60, t);
    sb_check(t);
    sb_check(int'(retry_cnt));
    wait_sig(S_FAULT, 1'b1, 60, t);
    sb_check(t);
    sb_check(int'(retry_cnt));
    sb_check(int'(pll_rst));
    tick(5);
    sb_push("fault_held", 1);
    sb_check(int'(fault));

    // Relock out of FAULT; first attempt times out, second locks.
    relock_req = 1'b1;
    c = cyc;
    tick(1);
    relock_req = 1'b0;
    sb_push("relock_fault_clr", 0);
    sb_push("relock_retry_clr", 0);
    sb_push("relock_pll_rst", 1);
    sb_push("relock_fall", c + 1 + RST);
    sb_push("relock_retry_rise", c + 1 + RST + TMO);
    sb_push("relock_retry_cnt1", 1);
    sb_push("relock_ready_rise", c + 1 + 2 * RST + TMO + STB + 1);
    sb_push("relock_run_retry_clr", 0);
    sb_check(int'(fault));
    sb_check(int'(retry_cnt));
    sb_check(int'(pll_rst));
    wait_sig(S_PLL_RST, 1'b0, 20, t);
    sb_check(t);
    wait_sig(S_PLL_RST, 1'b1, 60, t);
    sb_check(t);
    pll_locked = 1'b1;
    sb_check(int'(retry_cnt));
    wait_sig(S_READY, 1'b1, 60, t);
    sb_check(t);
    sb_check(int'(retry_cnt));

    // Saturation of the lock-loss counter.
    loop_ok = 1'b1;
    sb_push("loss_cnt_saturated", 255);
    sb_push("loss_loop_progress", 1);
    for (int i = 0; i < 260; i++) begin
      tick(2);
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      wait_sig(S_READY, 1'b0, 10, t);
      if (t < 0) loop_ok = 1'b0;
      wait_sig(S_READY, 1'b1, 40, t);
      if (t < 0) loop_ok = 1'b0;
    end
    sb_check(int'(lock_loss_cnt));
    sb_check(int'(loop_ok));

    sb_push("reset_ordering", 0);
    sb_check(int'(order_bad));
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
